uart_byte_rx: RTL

Receives one 8N1 UART frame from the serial line `rx` and presents the byte on a parallel bus with a one-cycle `rx_done` strobe. It is the receive side of the board's UART link: it shares the same `set_baud` encoding and system clock as the byte transmitter. It oversamples each bit 16×, validates the start bit, and reports framing errors.

---
 rtl/uart_byte_rx_if.sv | 16 +
 rtl/uart_byte_rx.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/uart_byte_rx_if.sv
// uart_byte_rx_if
//   Parallel result bus of the UART byte receiver.
//   data_byte : last correctly framed byte
//   rx_done   : one-cycle strobe, data_byte valid on the same cycle
//   frame_err : one-cycle strobe, stop bit sampled low
//   rx_busy   : receiver is inside a frame (any state but IDLE)
//   master modport = receiver side, slave modport = consumer side.
interface uart_byte_rx_if;
  logic [7:0] data_byte;
  logic       rx_done;
  logic       frame_err;
  logic       rx_busy;

  modport master (output data_byte, output rx_done, output frame_err, output rx_busy);
  modport slave  (input  data_byte, input  rx_done, input  frame_err, input  rx_busy);
endinterface

// File: rtl/uart_byte_rx.sv
// uart_byte_rx
//   8N1 UART receiver with 16x oversampling, start-bit validation and
//   framing-error reporting. Baud table fixed for a 50 MHz clk.
//   Optional build macro: UART_RX_MAJORITY_EN
//     defined   -> bit value is the 2-of-3 majority of samples s=7,8,9
//     undefined -> bit value is the single sample at s=8
//   Ports:
//     clk      : system clock
//     rst_n    : asynchronous active-low reset
//     rx       : asynchronous serial input, idle high
//     en_recv  : receiver enable, low forces IDLE
//     set_baud : baud select (0:9600 1:19200 2:38400 3:57600 4:115200 5-7:9600)
//     rx_bus   : result bus (uart_byte_rx_if.master)
//
//   state  | meaning
//   IDLE   | waiting for a falling edge on the synchronized line
//   START  | validating the start bit
//   DATA   | shifting in 8 data bits, LSB first
//   STOP   | sampling the stop bit
//   BREAK  | stop bit was low, waiting for the line to return high
module uart_byte_rx (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           rx,
  input  logic           en_recv,
  input  logic [2:0]     set_baud,
  uart_byte_rx_if.master rx_bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } state_t;

  state_t     state, state_nxt;
  logic       rx_meta, rxs, rxs_prev;
  logic       fall;
  logic [8:0] div_m1;
  logic [8:0] div_cnt;
  logic       tick;
  logic [3:0] s_idx;
  logic       wrap, decide;
  logic [2:0] bit_cnt;
  logic       samp8;
  logic       bit_val;
  logic [7:0] shreg;
  logic       cnt_clr;
  logic       done_d, err_d;
  logic [7:0] data_byte_q;
  logic       rx_done_q, frame_err_q;

  always_comb begin
    div_m1 = 9'd324;
    case (set_baud)
      3'd1:    div_m1 = 9'd162;
      3'd2:    div_m1 = 9'd80;
      3'd3:    div_m1 = 9'd53;
      3'd4:    div_m1 = 9'd26;
      default: div_m1 = 9'd324;
    endcase
  end

  // Both synchronizer flops and the history flop reset to the idle level so
  // that reset release never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta  <= 1'b1;
      rxs      <= 1'b1;
      rxs_prev <= 1'b1;
    end else begin
      rx_meta  <= rx;
      rxs      <= rx_meta;
      rxs_prev <= rxs;
    end
  end

  assign fall = rxs_prev & ~rxs;

  // Counters are held at zero in IDLE, so entering START starts them cleanly.
  assign cnt_clr = ~en_recv | (state == ST_IDLE);
  assign tick    = (div_cnt == div_m1);
  assign wrap    = tick & (s_idx == 4'd15);
  assign decide  = tick & (s_idx == 4'd9);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      s_idx   <= '0;
      bit_cnt <= '0;
    end else if (cnt_clr) begin
      div_cnt <= '0;
      s_idx   <= '0;
      bit_cnt <= '0;
    end else begin
      div_cnt <= tick ? 9'd0 : div_cnt + 9'd1;
      if (tick)
        s_idx <= s_idx + 4'd1;
      if ((state == ST_DATA) && wrap)
        bit_cnt <= bit_cnt + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      samp8 <= 1'b1;
    else if (tick && (s_idx == 4'd8))
      samp8 <= rxs;
  end

`ifdef UART_RX_MAJORITY_EN
  logic samp7;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      samp7 <= 1'b1;
    else if (tick && (s_idx == 4'd7))
      samp7 <= rxs;
  end

  // The s=9 sample is the live synchronized value on the decision tick.
  assign bit_val = (samp7 & samp8) | (samp7 & rxs) | (samp8 & rxs);
`else
  assign bit_val = samp8;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      shreg <= '0;
    else if ((state == ST_DATA) && decide)
      shreg <= {bit_val, shreg[7:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!en_recv) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (fall) state_nxt = ST_START;
        ST_START: begin
          if (decide && bit_val)
            state_nxt = ST_IDLE;
          else if (wrap)
            state_nxt = ST_DATA;
        end
        ST_DATA:  if (wrap && (bit_cnt == 3'd7)) state_nxt = ST_STOP;
        ST_STOP:  if (decide) state_nxt = bit_val ? ST_IDLE : ST_BREAK;
        ST_BREAK: if (rxs) state_nxt = ST_IDLE;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    done_d = 1'b0;
    err_d  = 1'b0;
    if (en_recv && (state == ST_STOP) && decide) begin
      done_d = bit_val;
      err_d  = ~bit_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
      data_byte_q <= 8'h00;
    end else begin
      rx_done_q   <= done_d;
      frame_err_q <= err_d;
      if (done_d)
        data_byte_q <= shreg;
    end
  end

  assign rx_bus.data_byte = data_byte_q;
  assign rx_bus.rx_done   = rx_done_q;
  assign rx_bus.frame_err = frame_err_q;
  assign rx_bus.rx_busy   = (state != ST_IDLE);

endmodule
